// File: rtl/RAM_2Port.sv
// Simple dual-port RAM: one write port, one registered read port.
// The storage array and read register are intentionally not reset.
module RAM_2Port #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 256
) (
  input  logic                     i_Wr_Clk,
  input  logic [$clog2(DEPTH)-1:0] i_Wr_Addr,
  input  logic                     i_Wr_DV,
  input  logic [WIDTH-1:0]         i_Wr_Data,
  input  logic                     i_Rd_Clk,
  input  logic [$clog2(DEPTH)-1:0] i_Rd_Addr,
  input  logic                     i_Rd_En,
  output logic [WIDTH-1:0]         o_Rd_Data
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  // Write port
  always_ff @(posedge i_Wr_Clk) begin
    if (i_Wr_DV) begin
      mem_q[i_Wr_Addr] <= i_Wr_Data;
    end
  end

  // Read port; the output register holds its value between reads
  always_ff @(posedge i_Rd_Clk) begin
    if (i_Rd_En) begin
      rd_data_q <= mem_q[i_Rd_Addr];
    end
  end

  assign o_Rd_Data = rd_data_q;

endmodule

// File: rtl/fifo_sync.sv
// Single-clock FIFO on top of RAM_2Port, with registered occupancy count,
// full/empty/almost flags and a one-cycle read-valid pulse.
module fifo_sync #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 256,
  parameter int AF_LEVEL = DEPTH - 4,
  parameter int AE_LEVEL = 4
) (
  input  logic                       i_Clk,
  input  logic                       i_Rst,
  input  logic                       i_Wr_DV,
  input  logic [WIDTH-1:0]           i_Wr_Data,
  output logic                       o_Full,
  output logic                       o_AF_Flag,
  input  logic                       i_Rd_En,
  output logic                       o_Rd_DV,
  output logic [WIDTH-1:0]           o_Rd_Data,
  output logic                       o_Empty,
  output logic                       o_AE_Flag,
  output logic [$clog2(DEPTH+1)-1:0] o_Count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_AF   = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] CNT_AE   = CNT_W'(AE_LEVEL);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             rd_dv_q, rd_dv_d;
  logic             full_s, empty_s;
  logic             wr_acc_s, rd_acc_s;
  logic [CNT_W-1:0] count_s;

  // Pointers wrap explicitly so non-power-of-two depths work
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? {PTR_W{1'b0}} : p + PTR_W'(1);
  endfunction

  // Full is judged before the read, so a full FIFO drops a simultaneous write
  assign full_s   = (count_q == CNT_FULL);
  assign empty_s  = (count_q == {CNT_W{1'b0}});
  assign wr_acc_s = i_Wr_DV & ~full_s & ~i_Rst;
  assign rd_acc_s = i_Rd_En & ~empty_s & ~i_Rst;

  // Next-state for pointers, occupancy and read-valid
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    rd_dv_d  = rd_acc_s;
    if (wr_acc_s) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (rd_acc_s) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({wr_acc_s, rd_acc_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
      rd_dv_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rd_dv_q  <= rd_dv_d;
    end
  end

  // Reset masks the visible state immediately, including a pending read pulse
  assign count_s   = i_Rst ? {CNT_W{1'b0}} : count_q;
  assign o_Count   = count_s;
  assign o_Full    = (count_s == CNT_FULL);
  assign o_Empty   = (count_s == {CNT_W{1'b0}});
  assign o_AF_Flag = (count_s >= CNT_AF);
  assign o_AE_Flag = (count_s <= CNT_AE);
  assign o_Rd_DV   = rd_dv_q & ~i_Rst;

  RAM_2Port #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .i_Wr_Clk  (i_Clk),
    .i_Wr_Addr (wr_ptr_q),
    .i_Wr_DV   (wr_acc_s),
    .i_Wr_Data (i_Wr_Data),
    .i_Rd_Clk  (i_Clk),
    .i_Rd_Addr (rd_ptr_q),
    .i_Rd_En   (rd_acc_s),
    .o_Rd_Data (o_Rd_Data)
  );

endmodule
